// File: rtl/addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIBBLE_W = 4;
    localparam int ID_W     = 1;

endpackage

// File: rtl/nibble_addsub.sv
// Shared 4-bit add/subtract slice; purely combinational, exposes carry into bit 3
// so the sequencer can derive signed overflow on the top nibble.
module nibble_addsub
    import addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                sub,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout,
    output logic                c3
);

    logic [NIBBLE_W-1:0] bx;
    logic [NIBBLE_W-1:0] low;
    logic [1:0]          top;

    assign bx  = b ^ {NIBBLE_W{sub}};
    // Split at bit 3 so the carry into the MSB is available separately
    assign low = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, bx[NIBBLE_W-2:0]} + {{(NIBBLE_W-1){1'b0}}, cin};
    assign c3  = low[NIBBLE_W-1];
    assign top = {1'b0, a[NIBBLE_W-1]} + {1'b0, bx[NIBBLE_W-1]} + {1'b0, c3};

    assign s    = {top[0], low[NIBBLE_W-2:0]};
    assign cout = top[1];

endmodule

// File: rtl/addsub_seq_arb.sv
// Two-requester round-robin front end feeding one nibble slice; operands are
// processed LSB nibble first with the carry chained through a register.
module addsub_seq_arb
    import addsub_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_sub,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_sub,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_carry,
    output logic         rsp_ovf
);

    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q;
    logic [ID_W-1:0]     last_q;
    logic [ID_W-1:0]     id_q;
    logic [ID_W-1:0]     grant;
    logic [W-1:0]        a_q, b_q, res_q, res_d;
    logic                sub_q, c_q;
    logic                accept, last_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic                cout_nib, c3_nib;

    logic                rsp_valid_q, rsp_carry_q, rsp_ovf_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [W-1:0]        rsp_sum_q;

    // On a tie the requester not granted last wins
    always_comb begin
        grant = '0;
        if (req0_valid && req1_valid) grant = ~last_q;
        else if (req1_valid)          grant = 1'b1;
    end

    assign accept   = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
    assign last_nib = (k_q == KW'(NIBBLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = RUN;
            RUN:     if (last_nib) state_d = DONE;
            DONE:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = accept && (grant == 1'b0);
        req1_ready = accept && (grant == 1'b1);
    end

    nibble_addsub u_slice (
        .a    (a_q[k_q*NIBBLE_W +: NIBBLE_W]),
        .b    (b_q[k_q*NIBBLE_W +: NIBBLE_W]),
        .sub  (sub_q),
        .cin  (c_q),
        .s    (s_nib),
        .cout (cout_nib),
        .c3   (c3_nib)
    );

    always_comb begin
        res_d = res_q;
        res_d[k_q*NIBBLE_W +: NIBBLE_W] = s_nib;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q         <= '0;
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
                k_q    <= '0;
                last_q <= grant;
            end else if (state_q == RUN) begin
                if (last_nib) begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_q;
                    rsp_sum_q   <= res_d;
                    rsp_carry_q <= cout_nib;
                    rsp_ovf_q   <= c3_nib ^ cout_nib;
                end else begin
                    k_q <= k_q + 1'b1;
                end
            end
        end
    end

    // Operand and partial-result storage needs no reset: always loaded on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= grant[0] ? req1_a : req0_a;
            b_q   <= grant[0] ? req1_b : req0_b;
            sub_q <= grant[0] ? req1_sub : req0_sub;
            c_q   <= grant[0] ? req1_sub : req0_sub;
            id_q  <= grant;
            res_q <= '0;
        end else if (state_q == RUN) begin
            res_q <= res_d;
            c_q   <= cout_nib;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_addsub_seq_arb.sv
// Scoreboard bench for addsub_seq_arb: drivers push expected results on each
// handshake, a monitor pops and compares on every rsp_valid strobe.
module tb_addsub_seq_arb;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_sub = 1'b0, req1_sub = 1'b0;
    logic         rsp_valid, rsp_id, rsp_carry, rsp_ovf;
    logic [W-1:0] rsp_sum;

    addsub_seq_arb #(.NIBBLES(NIBBLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_carry  (rsp_carry),
        .rsp_ovf    (rsp_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         id;
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   accepts    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub);
        exp_t       e;
        logic [W:0] full;
        longint     sa, sb_, sr;
        sa   = $signed(a);
        sb_  = $signed(b);
        sr   = sub ? (sa - sb_) : (sa + sb_);
        full = sub ? ({1'b0, a} + {1'b0, ~b} + 1) : ({1'b0, a} + {1'b0, b});
        e.id      = id;
        e.sum     = full[W-1:0];
        e.carry   = full[W];
        e.ovf     = (sr > 32767) || (sr < -32768);
        e.acc_cyc = 0;
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Drive one request, hold until accepted, push expectation at the handshake
    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        int   t = 0;
        bit   ok = 0;
        exp_t e;
        if (id == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_sub = sub; end
        else         begin req1_valid = 1; req1_a = a; req1_b = b; req1_sub = sub; end
        while (t < 200) begin
            @(negedge clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin ok = 1; break; end
            t++;
        end
        if (ok) begin
            e = model(id[0], a, b, sub);
            e.acc_cyc = cyc;
            sb.push_back(e);
            grant_log.push_back(id);
            accepts++;
        end else begin
            check($sformatf("accept_timeout_req%0d", id), 0, 1);
        end
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 0; else req1_valid = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && req0_ready && req1_ready) check("ready_exclusive", 1, 0);
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("rsp_latency", cyc - e.acc_cyc, NIBBLES + 1);
                check($sformatf("rsp{id,carry,ovf,sum}"),
                      {rsp_id, rsp_carry, rsp_ovf, rsp_sum},
                      {e.id, e.carry, e.ovf, e.sum});
            end
        end
    end

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin @(posedge clk); t++; end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic rand_stream(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
            issue(id, W'($urandom), W'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        int base, t;
        req0_valid = 1; req1_valid = 1;
        #3;
        check("reset_ready0", req0_ready, 0);
        check("reset_ready1", req1_ready, 0);
        check("reset_outputs", {rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum}, 0);
        req0_valid = 0; req1_valid = 0;
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;

        // Directed arithmetic cases
        issue(0, 16'h1234, 16'h0FCD, 0);
        issue(1, 16'h0009, 16'h0001, 1);
        issue(1, 16'h0001, 16'h0002, 1);
        issue(0, 16'h7FFF, 16'h0001, 0);
        issue(1, 16'hFFFF, 16'h0001, 0);
        issue(0, 16'h8000, 16'h0001, 1);
        drain();

        // Both valid continuously from reset: alternating grants
        rst = 1; @(posedge clk); #1 rst = 0;
        grant_log.delete();
        fork
            for (int i = 0; i < 3; i++) issue(0, W'($urandom), W'($urandom), 1'($urandom));
            for (int i = 0; i < 3; i++) issue(1, W'($urandom), W'($urandom), 1'($urandom));
        join
        drain();
        check("grant_count", grant_log.size(), 6);
        for (int i = 0; i < grant_log.size(); i++)
            check($sformatf("grant_order[%0d]", i), grant_log[i], i % 2);

        // req1 raised while req0 is being processed
        base = accepts;
        fork
            issue(0, 16'h4321, 16'h1111, 1);
            begin
                t = 0;
                while (accepts == base && t < 50) begin @(posedge clk); t++; end
                #1;
                fork
                    issue(1, 16'hABCD, 16'h1234, 0);
                    begin
                        for (int i = 0; i < NIBBLES + 1; i++) begin
                            @(negedge clk);
                            check("busy_ready1", req1_ready, 0);
                        end
                    end
                join
            end
        join
        drain();

        // Randomized concurrent traffic
        fork
            rand_stream(0, 15);
            rand_stream(1, 15);
        join
        drain();

        // Reset after two nibbles of a run
        base = accepts;
        fork issue(0, 16'h5A5A, 16'h1357, 0); join_none
        t = 0;
        while (accepts == base && t < 50) begin @(negedge clk); t++; end
        @(posedge clk); @(posedge clk); @(posedge clk); #2;
        rst = 1;
        #1;
        void'(sb.pop_back());
        check("midrun_rst_outputs", {rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_sum}, 0);
        wait fork;
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        check("midrun_rst_ready0", req0_ready, 0);
        check("midrun_rst_ready1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;
        repeat (NIBBLES + 2) @(posedge clk);
        #1 rst = 0;
        grant_log.delete();
        fork
            issue(0, 16'h0102, 16'h0304, 0);
            issue(1, 16'h0506, 16'h0708, 1);
        join
        drain();
        check("post_rst_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
